mips_mem_arbiter: RTL and testbench
===================================

// Module: mips_mem_arbiter
// PURPOSE
//  Shares one single-port unified memory between instruction fetch (IF) and the
//  load/store stage (D) of the MIPS32 core. Sequences wait states, drives byte lanes,
//  flags misaligned or out-of-range accesses, and raises stall to the pipeline.
// PARAMETERS
//  ADDR_W      32            byte-address width
//  DATA_W      32            data width; fixed at 32 (4 byte lanes)
//  WAIT_CYCLES 2             memory access cycles per transaction; must be >= 1
//  ADDR_LIMIT  32'h0000_0FFF highest valid byte address; above it -> error
// PORTS
//  CLK        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-low reset
//  if_req     in   1   fetch request; held with if_addr until if_ack
//  if_addr    in   32  fetch byte address
//  if_rdata   out  32  fetched word; valid with if_ack, held until next if_ack
//  if_ack     out  1   1-cycle completion pulse
//  if_err     out  1   with if_ack: misaligned or out of range (invpc)
//  d_req      in   1   data request; d_* held stable until d_ack
//  d_we       in   1   1 = store, 0 = load
//  d_size     in   2   0 = byte, 1 = half, 2 = word (3 -> error)
//  d_addr     in   32  data byte address
//  d_wdata    in   32  store data, right-justified
//  d_rdata    out  32  raw memory word; valid with d_ack (loads)
//  d_ack      out  1   1-cycle completion pulse
//  d_err      out  1   with d_ack: misaligned, bad size or out of range (iAddr)
//  mem_en     out  1   memory enable
//  mem_we     out  1   memory write enable
//  mem_be     out  4   byte enables; bit 3 = addr[1:0] == 3 (little-endian lanes)
//  mem_addr   out  30  word address (byte addr[31:2])
//  mem_wdata  out  32  store data replicated across lanes
//  mem_rdata  in   32  memory read data, valid in the last ACCESS cycle
//  stall      out  1   (if_req & ~if_ack) | (d_req & ~d_ack), combinational
// BEHAVIOUR
//  Reset (reset=0): state IDLE; all outputs 0, including rdata registers. No ack is
//   issued for an aborted transaction; requesters reissue it.
//  FSM states: IDLE, ACCESS, RESP, ERR.
//   IDLE   : on any request, choose the winner and check it.
//            Check fails -> ERR. Check passes -> ACCESS; load counter with WAIT_CYCLES-1.
//   ACCESS : mem_en=1; mem_we=d_we when D is granted; address, be and wdata held stable.
//            Counter decrements each cycle. At 0, capture mem_rdata -> RESP.
//   RESP   : ack=1 and rdata valid for the granted port -> IDLE.
//   ERR    : ack=1 and err=1 for the granted port; no mem_en -> IDLE.
//  Latency: request seen in cycle T0; ack in T0+WAIT_CYCLES+1; error ack in T0+1.
//  Arbitration happens only in IDLE. Fixed priority: D beats IF (older instruction).
//  Requests are sampled only in IDLE. Dropping req mid-transaction is illegal; the
//   access still completes and acks.
//  Checks: IF requires addr[1:0]==0. D: word requires [1:0]==0, half requires [0]==0,
//   byte is any. Every access requires addr <= ADDR_LIMIT.
//  mem_be: byte -> 1<<addr[1:0]; half -> 4'b0011<<addr[1:0]; word -> 4'b1111;
//   IF -> 4'b1111.
//  mem_wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
//  d_rdata on stores keeps its previous value.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: round-robin between IF and D. A last_grant flop is updated
//   on every grant. On a collision, the port not granted last wins. After reset,
//   last_grant=D, so IF wins the first collision.
//  MEM_ARB_RR_EN undefined: fixed D-over-IF priority, no last_grant flop.
// STRUCTURE
//  Package mips_mem_pkg: state enum; SZ_BYTE/SZ_HALF/SZ_WORD constants;
//   function be_gen(size, addr[1:0]).
//  Sub-module mips_mem_chk (combinational): alignment + range check and be/wdata
//   generation on the muxed winner request; one instance.
// TESTING (WAIT_CYCLES=2, ADDR_LIMIT=0xFFF)
//  Reset low with reqs high -> all outputs 0. Release with no req -> mem_en stays 0.
//  if_req, if_addr=0x4, mem_rdata=0x1C200003 -> mem_en=1, mem_addr=0x1 in T1,T2;
//   T3: if_ack=1, if_rdata=0x1C200003.
//  Both req at T0, store word d_addr=0x10, wdata=0xAABBCCDD -> mem_we=1, be=1111 T1-T2;
//   d_ack T3; IF access T5-T6, if_ack T7. With MEM_ARB_RR_EN: IF acked T3, D T7.
//  Store byte d_addr=0x13, wdata=0x000000AA -> mem_be=1000, mem_wdata=0xAAAAAAAA, mem_addr=0x4.
//  if_addr=0x6 -> T1 if_ack=if_err=1, mem_en never 1. Half d_addr=0x11 -> d_err.
//   Word d_addr=0x1000 -> d_err.
//  reset low during ACCESS -> mem_en=0 immediately, no ack. Reissued request then completes normally.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MIPS unified-memory arbiter.
// Holds the FSM state encoding, access-size codes and byte-lane generation.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2,
        ST_ERR    = 2'd3
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Little-endian lanes: bit n of the enable covers byte address offset n.
    function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_BYTE: return 4'b0001 << a;
            SZ_HALF: return 4'b0011 << a;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// Bus bundle between the pipeline requesters, the arbiter and the unified memory.
// The arbiter takes the slave view; the core/memory side takes the master view.
interface mips_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    logic              if_err;

    logic              d_req;
    logic              d_we;
    logic [1:0]        d_size;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;
    logic              d_err;

    logic              mem_en;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-3:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_ack, if_err, d_rdata, d_ack, d_err,
               mem_en, mem_we, mem_be, mem_addr, mem_wdata, stall
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_ack, if_err, d_rdata, d_ack, d_err,
               mem_en, mem_we, mem_be, mem_addr, mem_wdata, stall
    );
endinterface

// File: rtl/mips_mem_chk.sv
// Combinational legality check and lane formatting for the winning request.
// Fetches are always treated as aligned word reads with no write data.
module mips_mem_chk
    import mips_mem_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT = 'h0000_0FFF
) (
    input  logic              is_d_i,
    input  logic [1:0]        size_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              err_o,
    output logic [3:0]        be_o,
    output logic [DATA_W-1:0] wdata_o
);
    logic [1:0] eff_size;
    logic       misaligned;

    assign eff_size = is_d_i ? size_i : SZ_WORD;

    always_comb begin
        misaligned = 1'b1;
        wdata_o    = '0;
        case (eff_size)
            SZ_BYTE: begin
                misaligned = 1'b0;
                wdata_o    = {4{wdata_i[7:0]}};
            end
            SZ_HALF: begin
                misaligned = addr_i[0];
                wdata_o    = {2{wdata_i[15:0]}};
            end
            SZ_WORD: begin
                misaligned = |addr_i[1:0];
                wdata_o    = is_d_i ? wdata_i : '0;
            end
            default: begin
                misaligned = 1'b1;
                wdata_o    = '0;
            end
        endcase
    end

    assign err_o = misaligned | (addr_i > ADDR_LIMIT);
    assign be_o  = be_gen(eff_size, addr_i[1:0]);

endmodule

// File: rtl/mips_mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and load/store.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed D-over-IF priority.
module mips_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       WAIT_CYCLES = 2,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT  = 'h0000_0FFF
) (
    input logic               CLK,
    input logic               reset,
    mips_mem_arbiter_if.slave bus
);
    localparam int unsigned      CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              grant_d_q, grant_d_d;
    logic              start, capture, any_req, pick_d;
    logic [ADDR_W-1:0] sel_addr;
    logic              chk_err;
    logic [3:0]        chk_be;
    logic [DATA_W-1:0] chk_wdata;
    logic [ADDR_W-3:0] addr_q;
    logic [3:0]        be_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
    logic              access, done, in_err;

    assign any_req = bus.if_req | bus.d_req;

`ifdef MEM_ARB_RR_EN
    logic last_d_q;

    // On a collision the port that did not win last time goes first.
    assign pick_d = bus.d_req & (~bus.if_req | ~last_d_q);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset)                           last_d_q <= 1'b1;
        else if (state_q == ST_IDLE && any_req) last_d_q <= pick_d;
    end
`else
    assign pick_d = bus.d_req;
`endif

    assign sel_addr = pick_d ? bus.d_addr : bus.if_addr;

    mips_mem_chk #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .ADDR_LIMIT (ADDR_LIMIT)
    ) u_chk (
        .is_d_i  (pick_d),
        .size_i  (bus.d_size),
        .addr_i  (sel_addr),
        .wdata_i (bus.d_wdata),
        .err_o   (chk_err),
        .be_o    (chk_be),
        .wdata_o (chk_wdata)
    );

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            grant_d_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            grant_d_q <= grant_d_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grant_d_d = grant_d_q;
        start     = 1'b0;
        capture   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    start     = 1'b1;
                    grant_d_d = pick_d;
                    if (chk_err) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_ACCESS;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request fields are frozen at grant so the memory sees stable values for the whole access.
    always_ff @(posedge CLK) begin
        if (start) begin
            addr_q  <= sel_addr[ADDR_W-1:2];
            be_q    <= chk_be;
            wdata_q <= chk_wdata;
            we_q    <= pick_d & bus.d_we;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else if (capture) begin
            if (!grant_d_q)  if_rdata_q <= bus.mem_rdata;
            else if (!we_q)  d_rdata_q  <= bus.mem_rdata;
        end
    end

    assign access = (state_q == ST_ACCESS);
    assign in_err = (state_q == ST_ERR);
    assign done   = (state_q == ST_RESP) | in_err;

    assign bus.mem_en    = access;
    assign bus.mem_we    = access & we_q;
    assign bus.mem_be    = access ? be_q    : '0;
    assign bus.mem_addr  = access ? addr_q  : '0;
    assign bus.mem_wdata = access ? wdata_q : '0;

    assign bus.if_ack   = done & ~grant_d_q;
    assign bus.if_err   = in_err & ~grant_d_q;
    assign bus.d_ack    = done & grant_d_q;
    assign bus.d_err    = in_err & grant_d_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.d_rdata  = d_rdata_q;

    // Held low during reset so a core sitting in reset with requests high sees no stall.
    assign bus.stall = reset & ((bus.if_req & ~bus.if_ack) | (bus.d_req & ~bus.d_ack));

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter with a transaction-timeline reference model.
// Honours MEM_ARB_RR_EN when it is defined for the build.
module tb_mips_mem_arbiter;
    localparam int          W     = 2;
    localparam logic [31:0] LIMIT = 32'h0000_0FFF;

    localparam int S_EN = 0, S_WE = 1, S_BE = 2, S_ADDR = 3, S_WDATA = 4, S_IFACK = 5;
    localparam int S_IFERR = 6, S_IFRD = 7, S_DACK = 8, S_DERR = 9, S_DRD = 10, S_STALL = 11;

    logic CLK   = 1'b0;
    logic reset = 1'b0;

    mips_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mips_mem_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .WAIT_CYCLES (W),
        .ADDR_LIMIT  (LIMIT)
    ) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int          pin_cyc [128];
    int          pin_sel [128];
    logic [31:0] pin_exp [128];
    int          npins = 0;

    // Reference model: one transaction described by its start cycle and attributes.
    bit          m_have = 1'b0;
    int          m_t0   = 0;
    int          m_free = 0;
    bit          m_err, m_isd, m_we;
    bit          m_last_d = 1'b1;
    logic [3:0]  m_be;
    logic [31:0] m_addr_b, m_wdata;
    logic [31:0] m_if_rdata = '0;
    logic [31:0] m_d_rdata  = '0;

    function automatic bit bad_access(bit isd, logic [1:0] size, logic [31:0] a);
        int unsigned nbytes;
        if (isd && size == 2'd3) return 1'b1;
        nbytes = isd ? (32'd1 << size) : 32'd4;
        return ((a % nbytes) != 0) || (a > LIMIT);
    endfunction

    function automatic logic [3:0] lanes(bit isd, logic [1:0] size, logic [31:0] a);
        int unsigned nbytes, v;
        nbytes = isd ? (32'd1 << size) : 32'd4;
        v = ((32'd1 << nbytes) - 1) << (a % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] replicate(bit isd, logic [1:0] size, logic [31:0] wd);
        if (!isd)          return 32'h0;
        if (size == 2'd0)  return 32'(wd[7:0]) * 32'h0101_0101;
        if (size == 2'd1)  return 32'(wd[15:0]) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] outv(int s);
        case (s)
            S_EN:    return 32'(bus.mem_en);
            S_WE:    return 32'(bus.mem_we);
            S_BE:    return 32'(bus.mem_be);
            S_ADDR:  return 32'(bus.mem_addr);
            S_WDATA: return bus.mem_wdata;
            S_IFACK: return 32'(bus.if_ack);
            S_IFERR: return 32'(bus.if_err);
            S_IFRD:  return bus.if_rdata;
            S_DACK:  return 32'(bus.d_ack);
            S_DERR:  return 32'(bus.d_err);
            S_DRD:   return bus.d_rdata;
            default: return 32'(bus.stall);
        endcase
    endfunction

    function automatic string sname(int s);
        case (s)
            S_EN:    return "mem_en";
            S_WE:    return "mem_we";
            S_BE:    return "mem_be";
            S_ADDR:  return "mem_addr";
            S_WDATA: return "mem_wdata";
            S_IFACK: return "if_ack";
            S_IFERR: return "if_err";
            S_IFRD:  return "if_rdata";
            S_DACK:  return "d_ack";
            S_DERR:  return "d_err";
            S_DRD:   return "d_rdata";
            default: return "stall";
        endcase
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Compare process: check this cycle against the model, then advance the model
    // with the inputs that the coming rising edge will sample.
    initial begin
        bit e_en, e_ack;
        forever begin
            @(negedge CLK);
            e_en  = reset && m_have && !m_err && cyc > m_t0 && cyc <= m_t0 + W;
            e_ack = reset && m_have && cyc == m_t0 + (m_err ? 1 : W + 1);
            chk("mem_en",    32'(bus.mem_en),   32'(e_en));
            chk("mem_we",    32'(bus.mem_we),   32'(e_en && m_we));
            chk("mem_be",    32'(bus.mem_be),   e_en ? 32'(m_be) : 32'h0);
            chk("mem_addr",  32'(bus.mem_addr), e_en ? 32'(m_addr_b[31:2]) : 32'h0);
            chk("mem_wdata", bus.mem_wdata,     e_en ? m_wdata : 32'h0);
            chk("if_ack",    32'(bus.if_ack),   32'(e_ack && !m_isd));
            chk("if_err",    32'(bus.if_err),   32'(e_ack && !m_isd && m_err));
            chk("d_ack",     32'(bus.d_ack),    32'(e_ack && m_isd));
            chk("d_err",     32'(bus.d_err),    32'(e_ack && m_isd && m_err));
            chk("if_rdata",  bus.if_rdata,      reset ? m_if_rdata : 32'h0);
            chk("d_rdata",   bus.d_rdata,       reset ? m_d_rdata : 32'h0);
            chk("stall",     32'(bus.stall),    32'(reset && ((bus.if_req && !(e_ack && !m_isd)) ||
                                                               (bus.d_req && !(e_ack && m_isd)))));
            for (int i = 0; i < npins; i++)
                if (pin_cyc[i] == cyc)
                    chk({"pin_", sname(pin_sel[i])}, outv(pin_sel[i]), pin_exp[i]);

            if (!reset) begin
                m_have = 1'b0; m_free = 0; m_if_rdata = '0; m_d_rdata = '0; m_last_d = 1'b1;
            end else begin
                if (m_have && !m_err && cyc == m_t0 + W) begin
                    if (!m_isd)     m_if_rdata = bus.mem_rdata;
                    else if (!m_we) m_d_rdata  = bus.mem_rdata;
                end
                if (cyc >= m_free && (bus.if_req || bus.d_req)) begin
`ifdef MEM_ARB_RR_EN
                    m_isd    = bus.d_req && !(bus.if_req && m_last_d);
                    m_last_d = m_isd;
`else
                    m_isd    = bus.d_req;
`endif
                    m_addr_b = m_isd ? bus.d_addr : bus.if_addr;
                    m_err    = bad_access(m_isd, bus.d_size, m_addr_b);
                    m_we     = m_isd && bus.d_we;
                    m_be     = lanes(m_isd, bus.d_size, m_addr_b);
                    m_wdata  = replicate(m_isd, bus.d_size, bus.d_wdata);
                    m_have   = 1'b1;
                    m_t0     = cyc;
                    m_free   = cyc + (m_err ? 2 : W + 2);
                end
            end
            cyc++;
        end
    end

    task automatic step(int k);
        repeat (k) @(posedge CLK);
        #1;
    endtask

    task automatic pin(int c, int s, logic [31:0] e);
        pin_cyc[npins] = c;
        pin_sel[npins] = s;
        pin_exp[npins] = e;
        npins++;
    endtask

    task automatic d_setup(logic we, logic [1:0] size, logic [31:0] addr, logic [31:0] wd);
        bus.d_we = we; bus.d_size = size; bus.d_addr = addr; bus.d_wdata = wd; bus.d_req = 1'b1;
    endtask

    initial begin
        int t0;
        bus.if_req = 1'b1; bus.if_addr = 32'h0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 2'd2; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
        bus.mem_rdata = 32'hFFFF_FFFF;

        // Reset held with both requests high: everything quiet.
        step(1);
        t0 = cyc;
        pin(t0, S_EN, 0); pin(t0, S_STALL, 0); pin(t0, S_IFACK, 0); pin(t0, S_DACK, 0); pin(t0, S_IFRD, 0);
        step(2);
        bus.if_req = 1'b0; bus.d_req = 1'b0; reset = 1'b1;
        t0 = cyc;
        pin(t0 + 1, S_EN, 0); pin(t0 + 2, S_EN, 0);
        step(3);

        // Fetch from 0x4.
        bus.if_addr = 32'h4; bus.mem_rdata = 32'h1C20_0003; bus.if_req = 1'b1;
        t0 = cyc;
        pin(t0 + 1, S_EN, 1); pin(t0 + 1, S_ADDR, 1); pin(t0 + 1, S_STALL, 1);
        pin(t0 + 2, S_EN, 1); pin(t0 + 2, S_ADDR, 1);
        pin(t0 + 3, S_IFACK, 1); pin(t0 + 3, S_IFERR, 0); pin(t0 + 3, S_IFRD, 32'h1C20_0003);
        pin(t0 + 4, S_EN, 0);
        step(3); bus.if_req = 1'b0; step(2);

        // Load half from 0x12.
        bus.mem_rdata = 32'hCAFE_F00D;
        d_setup(1'b0, 2'd1, 32'h12, 32'h0);
        t0 = cyc;
        pin(t0 + 1, S_BE, 4'b1100); pin(t0 + 1, S_ADDR, 4); pin(t0 + 1, S_WE, 0);
        pin(t0 + 3, S_DACK, 1); pin(t0 + 3, S_DRD, 32'hCAFE_F00D);
        step(3); bus.d_req = 1'b0; step(2);

        // Collision: store word to 0x10 against a fetch from 0x8.
        bus.mem_rdata = 32'h1234_5678;
        d_setup(1'b1, 2'd2, 32'h10, 32'hAABB_CCDD);
        bus.if_addr = 32'h8; bus.if_req = 1'b1;
        t0 = cyc;
`ifdef MEM_ARB_RR_EN
        pin(t0 + 1, S_ADDR, 2); pin(t0 + 1, S_WE, 0);
        pin(t0 + 3, S_IFACK, 1); pin(t0 + 3, S_DACK, 0); pin(t0 + 3, S_IFRD, 32'h1234_5678);
        pin(t0 + 5, S_WE, 1); pin(t0 + 5, S_BE, 4'hF); pin(t0 + 5, S_ADDR, 4); pin(t0 + 5, S_WDATA, 32'hAABB_CCDD);
        pin(t0 + 7, S_DACK, 1); pin(t0 + 8, S_DRD, 32'hCAFE_F00D);
        step(3); bus.if_req = 1'b0; step(4); bus.d_req = 1'b0; step(2);
`else
        pin(t0 + 1, S_WE, 1); pin(t0 + 1, S_BE, 4'hF); pin(t0 + 1, S_ADDR, 4); pin(t0 + 1, S_WDATA, 32'hAABB_CCDD);
        pin(t0 + 2, S_WE, 1);
        pin(t0 + 3, S_DACK, 1); pin(t0 + 3, S_IFACK, 0);
        pin(t0 + 5, S_EN, 1); pin(t0 + 5, S_ADDR, 2); pin(t0 + 5, S_WE, 0);
        pin(t0 + 7, S_IFACK, 1); pin(t0 + 7, S_IFRD, 32'h1234_5678); pin(t0 + 8, S_DRD, 32'hCAFE_F00D);
        step(3); bus.d_req = 1'b0; step(4); bus.if_req = 1'b0; step(2);
`endif

        // Store byte to 0x13: lane 3, replicated data, load data untouched.
        d_setup(1'b1, 2'd0, 32'h13, 32'h0000_00AA);
        t0 = cyc;
        pin(t0 + 1, S_BE, 4'b1000); pin(t0 + 1, S_WDATA, 32'hAAAA_AAAA); pin(t0 + 1, S_ADDR, 4); pin(t0 + 1, S_WE, 1);
        pin(t0 + 3, S_DACK, 1); pin(t0 + 3, S_DRD, 32'hCAFE_F00D);
        step(3); bus.d_req = 1'b0; step(2);

        // Misaligned fetch.
        bus.if_addr = 32'h6; bus.if_req = 1'b1;
        t0 = cyc;
        pin(t0 + 1, S_IFACK, 1); pin(t0 + 1, S_IFERR, 1); pin(t0 + 1, S_EN, 0); pin(t0 + 2, S_EN, 0);
        step(1); bus.if_req = 1'b0; step(2);

        // Misaligned half, out-of-range word, bad size.
        d_setup(1'b0, 2'd1, 32'h11, 32'h0);
        t0 = cyc;
        pin(t0 + 1, S_DACK, 1); pin(t0 + 1, S_DERR, 1); pin(t0 + 1, S_EN, 0);
        step(1); bus.d_req = 1'b0; step(2);
        d_setup(1'b0, 2'd2, 32'h1000, 32'h0);
        t0 = cyc;
        pin(t0 + 1, S_DACK, 1); pin(t0 + 1, S_DERR, 1);
        step(1); bus.d_req = 1'b0; step(2);
        d_setup(1'b1, 2'd3, 32'h20, 32'h0);
        t0 = cyc;
        pin(t0 + 1, S_DERR, 1); pin(t0 + 1, S_EN, 0);
        step(1); bus.d_req = 1'b0; step(2);

        // Highest legal word.
        bus.mem_rdata = 32'h0BAD_BEEF;
        d_setup(1'b0, 2'd2, 32'hFFC, 32'h0);
        t0 = cyc;
        pin(t0 + 1, S_EN, 1); pin(t0 + 1, S_ADDR, 32'h3FF);
        pin(t0 + 3, S_DACK, 1); pin(t0 + 3, S_DERR, 0); pin(t0 + 3, S_DRD, 32'h0BAD_BEEF);
        step(3); bus.d_req = 1'b0; step(2);

        // Reset in the middle of an access, then the reissued fetch.
        bus.mem_rdata = 32'h55AA_55AA; bus.if_addr = 32'h20; bus.if_req = 1'b1;
        step(1);
        reset = 1'b0;
        t0 = cyc;
        pin(t0, S_EN, 0); pin(t0, S_IFACK, 0); pin(t0, S_IFRD, 0); pin(t0, S_DRD, 0); pin(t0, S_STALL, 0);
        pin(t0 + 1, S_IFACK, 0); pin(t0 + 2, S_IFACK, 0);
        step(2);
        reset = 1'b1;
        t0 = cyc;
        pin(t0 + 1, S_EN, 1); pin(t0 + 1, S_ADDR, 8);
        pin(t0 + 3, S_IFACK, 1); pin(t0 + 3, S_IFRD, 32'h55AA_55AA);
        step(3); bus.if_req = 1'b0; step(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
